// File: rtl/booth_seq_mult.sv
// Iterative radix-2 Booth multiplier: one add/subtract per cycle over WIDTH+1
// cycles, valid/ready handshakes on both sides, per-operation signed/unsigned mode.
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int AW = WIDTH + 2;
  localparam int QW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  m_ext;
  logic [QW-1:0]         q;
  logic                  q_1;
  logic [CW-1:0]         count;

  logic signed [AW-1:0]  acc_sum;
  logic signed [AW-1:0]  acc_sh;
  logic [QW-1:0]         q_sh;
  logic                  q1_sh;

  // Multiplicand carries one extra guard bit beyond Q so M = most-negative
  // can be subtracted without overflowing the accumulator.
  function automatic logic [AW-1:0] ext_m(input logic [WIDTH-1:0] v, input logic s);
    return s ? {{2{v[WIDTH-1]}}, v} : {2'b00, v};
  endfunction

  function automatic logic [QW-1:0] ext_q(input logic [WIDTH-1:0] v, input logic s);
    return s ? {v[WIDTH-1], v} : {1'b0, v};
  endfunction

  always_comb begin
    acc_sum = acc;
    case ({q[0], q_1})
      2'b10:   acc_sum = acc - m_ext;
      2'b01:   acc_sum = acc + m_ext;
      default: acc_sum = acc;
    endcase
    acc_sh = {acc_sum[AW-1], acc_sum[AW-1:1]};
    q_sh   = {acc_sum[0], q[QW-1:1]};
    q1_sh  = q[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      m_ext   <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m_ext <= ext_m(a, signed_mode);
            q     <= ext_q(b, signed_mode);
            acc   <= '0;
            q_1   <= 1'b0;
            count <= CW'(WIDTH + 1);
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_sh;
          q     <= q_sh;
          q_1   <= q1_sh;
          count <= count - 1'b1;
          // Last iteration: capture the product so it is stable throughout DONE.
          if (count == CW'(1)) begin
            product <= {acc_sh[WIDTH-2:0], q_sh};
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
